// File: rtl/md5_pwd_feeder.sv
// Password candidate generator for the MD5 cracking datapath: walks an 8-digit
// BCD space with a fixed decimal stride and offers each value as ASCII.
module md5_pwd_feeder #(
    parameter logic [31:0] START_BCD = 32'h00000000,
    parameter logic [31:0] END_BCD   = 32'h99999999,
    parameter int          STRIDE    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        found,
    output logic        cand_valid,
    input  logic        cand_ready,
    output logic [63:0] cand_ascii,
    output logic [31:0] cand_bcd,
    output logic        busy,
    output logic        exhausted,
    output logic        matched,
    output logic [31:0] elapsed,
    output logic [31:0] issued
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FOUND = 2'd2;
    localparam logic [1:0] S_EX    = 2'd3;

    logic [1:0]  state;
    logic        handshake;
    logic        adv_carry;
    logic [31:0] adv_bcd;

    function automatic logic [63:0] to_ascii(input logic [31:0] b);
        logic [63:0] r;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[d*8 +: 8] = {4'h3, b[d*4 +: 4]};
        end
        return r;
    endfunction

    // Decimal add of STRIDE with digit-wise carry ripple; bit 32 is the carry out of digit 7.
    function automatic logic [32:0] bcd_add(input logic [31:0] a);
        logic [31:0] r;
        logic [4:0]  c;
        logic [4:0]  sum;
        r = '0;
        c = 5'(STRIDE);
        for (int d = 0; d < 8; d++) begin
            sum = {1'b0, a[d*4 +: 4]} + c;
            if (sum > 5'd9) begin
                r[d*4 +: 4] = 4'(sum - 5'd10);
                c = 5'd1;
            end else begin
                r[d*4 +: 4] = sum[3:0];
                c = 5'd0;
            end
        end
        return {c[0], r};
    endfunction

    // Valid/ready: cand_valid depends only on registered state; a candidate
    // transfers on any cycle with cand_valid & cand_ready, and all candidate
    // outputs hold while cand_valid is high and cand_ready is low.
    assign cand_valid = (state == S_RUN);
    assign busy       = (state == S_RUN);
    assign exhausted  = (state == S_EX);
    assign matched    = (state == S_FOUND);
    assign handshake  = cand_valid & cand_ready;

    always_comb begin
        {adv_carry, adv_bcd} = bcd_add(cand_bcd);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cand_bcd   <= START_BCD;
            cand_ascii <= to_ascii(START_BCD);
            elapsed    <= '0;
            issued     <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (elapsed != 32'hFFFFFFFF) elapsed <= elapsed + 32'd1;
                    if (handshake && issued != 32'hFFFFFFFF) issued <= issued + 32'd1;
                    // A match freezes the candidate even if it transferred this cycle.
                    if (found) begin
                        state <= S_FOUND;
                    end else if (handshake) begin
                        if (adv_carry || adv_bcd > END_BCD) begin
                            state <= S_EX;
                        end else begin
                            cand_bcd   <= adv_bcd;
                            cand_ascii <= to_ascii(adv_bcd);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state      <= S_RUN;
                        cand_bcd   <= START_BCD;
                        cand_ascii <= to_ascii(START_BCD);
                        elapsed    <= '0;
                        issued     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_pwd_feeder.sv
// Bench for md5_pwd_feeder: four differently parameterised feeders checked
// every cycle against a decimal-arithmetic model, plus hand-computed checkpoints.
module tb_md5_pwd_feeder;

    localparam logic [31:0] P_START [4] = '{32'h00000000, 32'h00000099, 32'h99999998, 32'h00000988};
    localparam logic [31:0] P_END   [4] = '{32'h99999999, 32'h00000110, 32'h99999999, 32'h00001050};
    localparam int          P_STRIDE[4] = '{1, 3, 1, 7};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  start_v, found_v, ready_v;
    logic [3:0]  valid_v, busy_v, ex_v, mt_v;
    logic [63:0] ascii_a[4];
    logic [31:0] bcd_a[4], el_a[4], iss_a[4];

    int n_checks = 0;
    int n_pass   = 0;

    // model: 0 idle, 1 run, 2 found, 3 exhausted
    int          m_st[4];
    logic [31:0] m_bcd[4], m_el[4], m_iss[4];

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    md5_pwd_feeder #(.START_BCD(P_START[0]), .END_BCD(P_END[0]), .STRIDE(P_STRIDE[0])) u0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .found(found_v[0]),
        .cand_valid(valid_v[0]), .cand_ready(ready_v[0]), .cand_ascii(ascii_a[0]),
        .cand_bcd(bcd_a[0]), .busy(busy_v[0]), .exhausted(ex_v[0]), .matched(mt_v[0]),
        .elapsed(el_a[0]), .issued(iss_a[0]));
    md5_pwd_feeder #(.START_BCD(P_START[1]), .END_BCD(P_END[1]), .STRIDE(P_STRIDE[1])) u1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .found(found_v[1]),
        .cand_valid(valid_v[1]), .cand_ready(ready_v[1]), .cand_ascii(ascii_a[1]),
        .cand_bcd(bcd_a[1]), .busy(busy_v[1]), .exhausted(ex_v[1]), .matched(mt_v[1]),
        .elapsed(el_a[1]), .issued(iss_a[1]));
    md5_pwd_feeder #(.START_BCD(P_START[2]), .END_BCD(P_END[2]), .STRIDE(P_STRIDE[2])) u2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .found(found_v[2]),
        .cand_valid(valid_v[2]), .cand_ready(ready_v[2]), .cand_ascii(ascii_a[2]),
        .cand_bcd(bcd_a[2]), .busy(busy_v[2]), .exhausted(ex_v[2]), .matched(mt_v[2]),
        .elapsed(el_a[2]), .issued(iss_a[2]));
    md5_pwd_feeder #(.START_BCD(P_START[3]), .END_BCD(P_END[3]), .STRIDE(P_STRIDE[3])) u3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[3]), .found(found_v[3]),
        .cand_valid(valid_v[3]), .cand_ready(ready_v[3]), .cand_ascii(ascii_a[3]),
        .cand_bcd(bcd_a[3]), .busy(busy_v[3]), .exhausted(ex_v[3]), .matched(mt_v[3]),
        .elapsed(el_a[3]), .issued(iss_a[3]));

    function automatic int dec(input logic [31:0] b);
        int v = 0;
        for (int d = 7; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] enc(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_ascii(input logic [31:0] b);
        logic [63:0] r = '0;
        int x = dec(b);
        for (int k = 0; k < 8; k++) begin
            r[k*8 +: 8] = 8'(48 + x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: decimal integers, stride add, bound compare.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i]  <= 0;
                m_bcd[i] <= P_START[i];
                m_el[i]  <= '0;
                m_iss[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == 1) begin
                    m_el[i] <= sat_inc(m_el[i]);
                    if (ready_v[i]) m_iss[i] <= sat_inc(m_iss[i]);
                    if (found_v[i]) m_st[i] <= 2;
                    else if (ready_v[i]) begin
                        if (dec(m_bcd[i]) + P_STRIDE[i] > 99999999 ||
                            dec(m_bcd[i]) + P_STRIDE[i] > dec(P_END[i])) m_st[i] <= 3;
                        else m_bcd[i] <= enc(dec(m_bcd[i]) + P_STRIDE[i]);
                    end
                end else if (start_v[i]) begin
                    m_st[i]  <= 1;
                    m_bcd[i] <= P_START[i];
                    m_el[i]  <= '0;
                    m_iss[i] <= '0;
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("u%0d_valid", i), 64'(valid_v[i]), 64'(m_st[i] == 1));
                check($sformatf("u%0d_busy", i), 64'(busy_v[i]), 64'(m_st[i] == 1));
                check($sformatf("u%0d_matched", i), 64'(mt_v[i]), 64'(m_st[i] == 2));
                check($sformatf("u%0d_exhausted", i), 64'(ex_v[i]), 64'(m_st[i] == 3));
                check($sformatf("u%0d_bcd", i), 64'(bcd_a[i]), 64'(m_bcd[i]));
                check($sformatf("u%0d_ascii", i), ascii_a[i], exp_ascii(m_bcd[i]));
                check($sformatf("u%0d_elapsed", i), 64'(el_a[i]), 64'(m_el[i]));
                check($sformatf("u%0d_issued", i), 64'(iss_a[i]), 64'(m_iss[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic collect_run(input int i);
        int guard = 0;
        got_q.delete();
        while (valid_v[i] && guard < 60) begin
            if (ready_v[i]) got_q.push_back(bcd_a[i]);
            tick();
            guard++;
        end
        check($sformatf("u%0d_run_ended", i), 64'(valid_v[i]), 64'd0);
        check($sformatf("u%0d_seq_len", i), 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("u%0d_seq_%0d", i, k), 64'(got_q[k]), 64'(exp_q[k]));
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        start_v = '0; found_v = '0; ready_v = '0;
        repeat (3) tick();
        check("rst_valid", 64'(valid_v[0]), 64'd0);
        check("rst_bcd_u0", 64'(bcd_a[0]), 64'h0);
        check("rst_ascii_u2", ascii_a[2], 64'h3939393939393938);
        reset_n = 1'b1;
        tick();

        // Stride-1 walk with stalls and a match at 00000042.
        ready_v[0] = 1'b1;
        pulse_start(0);
        check("u0_first_bcd", 64'(bcd_a[0]), 64'h0);
        repeat (10) tick();
        check("u0_ascii_10", ascii_a[0], 64'h3030303030303130);
        check("u0_issued_10", 64'(iss_a[0]), 64'd10);
        ready_v[0] = 1'b0;
        tick(); tick();
        check("u0_stall_bcd", 64'(bcd_a[0]), 64'h10);
        check("u0_stall_issued", 64'(iss_a[0]), 64'd10);
        check("u0_stall_elapsed", 64'(el_a[0]), 64'd12);
        ready_v[0] = 1'b1;
        tick();
        check("u0_resume_bcd", 64'(bcd_a[0]), 64'h11);
        check("u0_resume_elapsed", 64'(el_a[0]), 64'd13);
        guard = 0;
        while (bcd_a[0] != 32'h42 && guard < 500) begin
            tick();
            ready_v[0] = 1'($urandom_range(0, 1));
            if (bcd_a[0] == 32'h42) break;
            guard++;
        end
        check("u0_reach_42", 64'(bcd_a[0]), 64'h42);
        ready_v[0] = 1'b1; found_v[0] = 1'b1;
        tick();
        found_v[0] = 1'b0;
        check("u0_found_matched", 64'(mt_v[0]), 64'd1);
        check("u0_found_bcd", 64'(bcd_a[0]), 64'h42);
        check("u0_found_issued", 64'(iss_a[0]), 64'd43);
        check("u0_found_busy", 64'(busy_v[0]), 64'd0);
        repeat (3) tick();

        // Stride 3 across a two-digit carry up to END 110.
        ready_v[1] = 1'b1;
        pulse_start(1);
        exp_q = '{32'h099, 32'h102, 32'h105, 32'h108};
        collect_run(1);
        check("u1_exhausted", 64'(ex_v[1]), 64'd1);
        check("u1_issued", 64'(iss_a[1]), 64'd4);

        // Carry out of the most significant digit, then restart.
        ready_v[2] = 1'b1;
        pulse_start(2);
        exp_q = '{32'h99999998, 32'h99999999};
        collect_run(2);
        check("u2_exhausted", 64'(ex_v[2]), 64'd1);
        check("u2_elapsed", 64'(el_a[2]), 64'd2);
        pulse_start(2);
        check("u2_restart_bcd", 64'(bcd_a[2]), 64'h99999998);
        check("u2_restart_issued", 64'(iss_a[2]), 64'd0);
        check("u2_restart_exh", 64'(ex_v[2]), 64'd0);
        ready_v[2] = 1'b0;
        repeat (2) tick();

        // Stride 7 with random ready: full run to END, then a run with random start/found.
        pulse_start(3);
        guard = 0;
        while (valid_v[3] && guard < 400) begin
            ready_v[3] = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("u3_exhausted", 64'(ex_v[3]), 64'd1);
        check("u3_last_bcd", 64'(bcd_a[3]), 64'h1044);
        check("u3_issued", 64'(iss_a[3]), 64'd9);
        pulse_start(3);
        guard = 0;
        while (valid_v[3] && guard < 400) begin
            ready_v[3] = 1'($urandom_range(0, 1));
            start_v[3] = ($urandom_range(0, 9) == 0);
            found_v[3] = ($urandom_range(0, 14) == 0);
            tick();
            guard++;
        end
        start_v[3] = 1'b0;
        check("u3_run2_ended", 64'(valid_v[3]), 64'd0);
        for (int k = 0; k < 6; k++) begin
            found_v[3] = 1'($urandom_range(0, 1));
            ready_v[3] = 1'($urandom_range(0, 1));
            tick();
        end
        found_v[3] = 1'b0;

        // Asynchronous reset in the middle of a run.
        ready_v[0] = 1'b1;
        pulse_start(0);
        guard = 0;
        while (bcd_a[0] != 32'h500 && guard < 700) begin
            tick();
            guard++;
        end
        check("u0_reach_500", 64'(bcd_a[0]), 64'h500);
        #1 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid_v[0]), 64'd0);
        check("arst_bcd", 64'(bcd_a[0]), 64'h0);
        check("arst_ascii", ascii_a[0], 64'h3030303030303030);
        check("arst_issued", 64'(iss_a[0]), 64'd0);
        check("arst_elapsed", 64'(el_a[0]), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start(0);
        check("u0_rerun_valid", 64'(valid_v[0]), 64'd1);
        check("u0_rerun_bcd", 64'(bcd_a[0]), 64'h0);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md5_pwd_feeder.md
Name: md5_pwd_feeder

Overview:
- Candidate generator directly upstream of the MD5 cracking datapath.
- Walks an 8-digit decimal password space in BCD from a lane start value with a fixed decimal stride.
- Presents each candidate as 8 ASCII bytes over a valid/ready handshake to the MD5 core.
- Stops on a match report from the comparator, or when the space is exhausted; reports elapsed cycles and issued-candidate count for the LCD row.

Parameters:
- START_BCD, 32'h00000000: first candidate of this lane (8 BCD digits, digit 7 = MSD in [31:28]).
- END_BCD, 32'h99999999: last candidate allowed (inclusive, BCD).
- STRIDE, 1: decimal increment per issued candidate, legal range 1..9 (lane count when several feeders interleave).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; (re)starts the search
- found  in  1  one-cycle pulse from hash comparator: current search has matched
- cand_valid  out  1  candidate on cand_ascii/cand_bcd is valid
- cand_ready  in  1  MD5 core accepts candidate this cycle
- cand_ascii  out  64  candidate as ASCII; [63:56] = MSD, digit d encodes 8'h30+d
- cand_bcd  out  32  same candidate in BCD
- busy  out  1  high in RUN
- exhausted  out  1  high in DONE_EX
- matched  out  1  high in DONE_FOUND
- elapsed  out  32  clk cycles spent in RUN, saturating at 32'hFFFFFFFF
- issued  out  32  number of completed handshakes since last start, saturating

Behaviour:
- Reset (async, reset_n=0): state IDLE; cand_valid=0, busy=0, exhausted=0, matched=0, elapsed=0, issued=0, cand_bcd=START_BCD, cand_ascii=ASCII(START_BCD).
- States: IDLE, RUN, DONE_FOUND, DONE_EX.
- IDLE/DONE_* + start:
  - next cycle RUN, cand_bcd=START_BCD, elapsed=0, issued=0, exhausted=0, matched=0.
  - cand_valid=1 from the first RUN cycle (1-cycle latency after start).
- start while in RUN: ignored.
- RUN:
  - cand_valid=1; elapsed increments every RUN cycle.
  - Handshake = cand_valid & cand_ready. On a handshake, issued increments.
  - Outputs hold stable while cand_valid & !cand_ready.
  - Handshake, no found:
    - next = cand_bcd + STRIDE, BCD add with digit carry ripple (digit >9 -> subtract 10, carry 1).
    - If carry out of digit 7, or next > END_BCD -> DONE_EX, cand_bcd unchanged.
    - Else cand_bcd = next, stay in RUN.
  - found (with or without handshake): -> DONE_FOUND. found has priority: cand_bcd does not advance; a simultaneous handshake still counts in issued.
- DONE_FOUND: matched=1, cand_valid=0, busy=0; cand_bcd, elapsed and issued frozen.
- DONE_EX: exhausted=1, cand_valid=0, busy=0; cand_bcd, elapsed and issued frozen.
- found outside RUN: ignored.
- START_BCD > END_BCD: first candidate still issued once, then DONE_EX.
- Saturation: elapsed and issued hold at all-ones, no wrap.
- reset_n low mid-RUN: immediate return to reset values; no partial handshake is remembered.
- cand_ascii is a registered function of cand_bcd, same cycle; no combinational path from cand_ready to cand_valid.

Test Plan:
- Defaults; reset, start, cand_ready=1 constant -> cand_bcd 00000000, 00000001, ...; after 10 handshakes cand_ascii=64'h3030303030303130, issued=10.
- START_BCD=32'h00000099, STRIDE=3, END_BCD=32'h00000110 -> sequence 099,102,105,108; at 108 the next value 111 exceeds END -> DONE_EX, exhausted=1, issued=4, cand_valid=0.
- cand_ready toggled 1,0,0,1 -> value held across the stall cycles; issued increments only on ready-high cycles; elapsed counts all RUN cycles.
- found pulsed in the same cycle as the handshake of candidate 00000042 -> matched=1, cand_bcd stays 00000042, issued includes it, busy=0 next cycle.
- START_BCD=32'h99999998, STRIDE=1, default END -> issue 99999998, 99999999, then carry out -> DONE_EX; start again -> restarts at 99999998, counters cleared.
- reset_n pulled low mid-RUN at cand_bcd 00000500 -> asynchronously all outputs reset; start re-runs from START_BCD.
